// File: rtl/rvfi_bus_env.sv
// Wishbone-classic slave environment for rvfi checks: bounded solver acks,
// a shared shadow memory for read consistency, sticky master protocol flags.
module rvfi_bus_env #(
  parameter int NCH          = 2,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MIN_WAIT     = 0,
  parameter int MAX_WAIT     = 3,
  parameter int SHADOW_EN    = 1,
  parameter int SHADOW_DEPTH = 4,
  localparam int WW          = $clog2(MAX_WAIT + 2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    i_cyc,
  input  logic [NCH*AW-1:0] i_adr,
  input  logic [NCH-1:0]    i_we,
  input  logic [NCH*DW/8-1:0] i_sel,
  input  logic [NCH*DW-1:0] i_dat,
  input  logic [NCH-1:0]    i_nd_ack,
  input  logic [NCH*DW-1:0] i_nd_rdt,
  output logic [NCH-1:0]    o_ack,
  output logic [NCH*DW-1:0] o_rdt,
  output logic [NCH-1:0]    o_err_drop,
  output logic [NCH-1:0]    o_err_chg,
  output logic [NCH*WW-1:0] o_wait
);
  localparam int BW  = DW / 8;
  localparam int WAW = AW - 2;
  localparam int PW  = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t         st_q  [NCH];
  state_t         st_d  [NCH];
  logic [WW-1:0]  cnt_q [NCH];
  logic [WW-1:0]  cnt_d [NCH];
  logic [AW-1:0]  adr_q [NCH];
  logic [AW-1:0]  adr_d [NCH];
  logic [BW-1:0]  sel_q [NCH];
  logic [BW-1:0]  sel_d [NCH];
  logic [DW-1:0]  dat_q [NCH];
  logic [DW-1:0]  dat_d [NCH];
  logic [DW-1:0]  rdt_q [NCH];
  logic [DW-1:0]  rdt_d [NCH];
  logic [NCH-1:0] we_q, we_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] drop_q, drop_d;
  logic [NCH-1:0] chg_q, chg_d;

  logic [WAW-1:0] sh_adr_q [SHADOW_DEPTH];
  logic [WAW-1:0] sh_adr_d [SHADOW_DEPTH];
  logic [DW-1:0]  sh_dat_q [SHADOW_DEPTH];
  logic [DW-1:0]  sh_dat_d [SHADOW_DEPTH];
  logic [BW-1:0]  sh_vld_q [SHADOW_DEPTH];
  logic [BW-1:0]  sh_vld_d [SHADOW_DEPTH];
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           sh_hit;
  int             sh_idx;

  // Live inputs while idle, captured copy while waiting
  logic [AW-1:0]  req_adr [NCH];
  logic [BW-1:0]  req_sel [NCH];
  logic [DW-1:0]  req_dat [NCH];
  logic [NCH-1:0] req_we;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] diff;
  int             wcnt [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      if (st_q[c] == S_IDLE) begin
        req_adr[c] = i_adr[c*AW +: AW];
        req_we[c]  = i_we[c];
        req_sel[c] = i_sel[c*BW +: BW];
        req_dat[c] = i_dat[c*DW +: DW];
        wcnt[c]    = 0;
      end else begin
        req_adr[c] = adr_q[c];
        req_we[c]  = we_q[c];
        req_sel[c] = sel_q[c];
        req_dat[c] = dat_q[c];
        wcnt[c]    = int'(cnt_q[c]) + 1;
      end
      diff[c] = (i_adr[c*AW +: AW] != adr_q[c]) ||
                (i_we[c] != we_q[c]) ||
                (i_sel[c*BW +: BW] != sel_q[c]) ||
                (i_dat[c*DW +: DW] != dat_q[c]);
      fire[c] = i_cyc[c] && (st_q[c] != S_ACK) &&
                ((wcnt[c] >= MIN_WAIT && i_nd_ack[c]) ||
                 wcnt[c] == MAX_WAIT);
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    drop_d   = drop_q;
    chg_d    = chg_q;
    ack_d    = fire;
    sh_adr_d = sh_adr_q;
    sh_dat_d = sh_dat_q;
    sh_vld_d = sh_vld_q;
    ptr_d    = ptr_q;
    sh_hit   = 1'b0;
    sh_idx   = 0;
    for (int c = 0; c < NCH; c++) begin
      rdt_d[c] = '0;
      unique case (st_q[c])
        S_IDLE: if (i_cyc[c]) begin
          adr_d[c] = req_adr[c];
          we_d[c]  = req_we[c];
          sel_d[c] = req_sel[c];
          dat_d[c] = req_dat[c];
          cnt_d[c] = '0;
          st_d[c]  = fire[c] ? S_ACK : S_WAIT;
        end
        S_WAIT: if (!i_cyc[c]) begin
          st_d[c]   = S_IDLE;
          cnt_d[c]  = '0;
          drop_d[c] = 1'b1;
        end else begin
          if (diff[c]) chg_d[c] = 1'b1;
          cnt_d[c] = cnt_q[c] + 1'b1;
          if (fire[c]) st_d[c] = S_ACK;
        end
        default: begin
          st_d[c]  = S_IDLE;
          cnt_d[c] = '0;
        end
      endcase
      // Reads see the shadow as it stood before this cycle's writes
      if (fire[c] && !req_we[c]) begin
        for (int b = 0; b < BW; b++) begin
          rdt_d[c][8*b +: 8] = i_nd_rdt[c*DW + 8*b +: 8];
          if (SHADOW_EN != 0) begin
            for (int e = 0; e < SHADOW_DEPTH; e++) begin
              if (sh_vld_q[e][b] && sh_adr_q[e] == req_adr[c][AW-1:2])
                rdt_d[c][8*b +: 8] = sh_dat_q[e][8*b +: 8];
            end
          end
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (SHADOW_EN != 0 && fire[c] && req_we[c]) begin
        sh_hit = 1'b0;
        sh_idx = int'(ptr_d);
        for (int e = 0; e < SHADOW_DEPTH; e++) begin
          if (sh_vld_d[e] != '0 && sh_adr_d[e] == req_adr[c][AW-1:2]) begin
            sh_hit = 1'b1;
            sh_idx = e;
          end
        end
        if (!sh_hit) begin
          sh_adr_d[sh_idx] = req_adr[c][AW-1:2];
          sh_vld_d[sh_idx] = '0;
          ptr_d = (int'(ptr_d) == SHADOW_DEPTH - 1) ? '0 : ptr_d + 1'b1;
        end
        for (int b = 0; b < BW; b++) begin
          if (req_sel[c][b]) begin
            sh_dat_d[sh_idx][8*b +: 8] = req_dat[c][8*b +: 8];
            sh_vld_d[sh_idx][b] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    adr_q    <= adr_d;
    we_q     <= we_d;
    sel_q    <= sel_d;
    dat_q    <= dat_d;
    sh_adr_q <= sh_adr_d;
    sh_dat_q <= sh_dat_d;
    if (reset) begin
      st_q     <= '{default: S_IDLE};
      cnt_q    <= '{default: '0};
      rdt_q    <= '{default: '0};
      sh_vld_q <= '{default: '0};
      ack_q    <= '0;
      drop_q   <= '0;
      chg_q    <= '0;
      ptr_q    <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      rdt_q    <= rdt_d;
      sh_vld_q <= sh_vld_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
      chg_q    <= chg_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      o_rdt[c*DW +: DW]  = rdt_q[c];
      o_wait[c*WW +: WW] = cnt_q[c];
    end
  end

  assign o_ack      = ack_q;
  assign o_err_drop = drop_q;
  assign o_err_chg  = chg_q;

endmodule
